// File: rtl/branch_target_predictor.sv
// branch_target_predictor: 64-entry direct-mapped branch target buffer with
// 2-bit saturating direction counters. A lookup on the next PC is registered at
// each clock edge, so the outputs line up with the PC that fetch is currently
// presenting. The execute stage trains the tables through a single update port.
// Reset does not clear the tables with flop resets. Instead, a sweep state
// machine writes one entry per cycle, which keeps the storage RAM-inferable.
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 26,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_pc_next,
  input  logic                  i_update_valid,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_taken,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic                  o_prediction,
  output logic [ADDR_WIDTH-1:0] o_target
);

  localparam int DEPTH = 1 << INDEX_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            ctr;
    logic [TAG_BITS-1:0]   tag;
    logic [ADDR_WIDTH-1:0] tgt;
  } entry_t;

  // Value written into every entry by the init sweep: invalid, weakly not-taken.
  localparam entry_t CLEAR_ENTRY = '{valid: 1'b0, ctr: 2'b01, tag: '0, tgt: '0};

  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_sweep_idx;
  entry_t                r_table [DEPTH];
  entry_t                r_rd_entry;
  logic [TAG_BITS-1:0]   r_rd_tag;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  entry_t                w_upd_old;
  logic                  w_upd_hit;
  logic [1:0]            w_ctr_next;
  logic                  w_we;
  logic [INDEX_BITS-1:0] w_widx;
  entry_t                w_wdata;
  logic                  w_unused_lsbs;

  // The byte-offset bits never select an entry, because branches are word aligned.
  assign w_unused_lsbs = ^{i_pc_next[1:0], i_update_pc[1:0]};

  assign w_lk_idx  = i_pc_next[INDEX_BITS+1:2];
  assign w_lk_tag  = i_pc_next[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_upd_idx = i_update_pc[INDEX_BITS+1:2];
  assign w_upd_tag = i_update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_upd_old = r_table[w_upd_idx];
  assign w_upd_hit = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);

  // Compute the saturating counter step for a resolved branch that hits in the table.
  always_comb begin
    w_ctr_next = w_upd_old.ctr;
    if (i_update_taken) begin
      if (w_upd_old.ctr != 2'b11) w_ctr_next = w_upd_old.ctr + 2'b01;
    end else begin
      if (w_upd_old.ctr != 2'b00) w_ctr_next = w_upd_old.ctr - 2'b01;
    end
  end

  // Select the table's single write port: the sweep owns it in INIT, and training owns it in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_upd_idx;
    w_wdata = w_upd_old;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_we    = 1'b1;
        w_widx  = r_sweep_idx;
        w_wdata = CLEAR_ENTRY;
      end else if (i_update_valid) begin
        if (w_upd_hit) begin
          w_we        = 1'b1;
          w_wdata.ctr = w_ctr_next;
          if (i_update_taken) w_wdata.tgt = i_update_target;
        end else if (i_update_taken) begin
          w_we    = 1'b1;
          w_wdata = '{valid: 1'b1, ctr: 2'b10, tag: w_upd_tag, tgt: i_update_target};
        end
      end
    end
  end

  // Table storage: plain write port with no reset, so synthesis can map it onto RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_table[w_widx] <= w_wdata;
  end

  // Register the lookup. A write to the same index in the same cycle is forwarded (write-first).
  always_ff @(posedge clk) begin
    if (w_we && (w_widx == w_lk_idx)) r_rd_entry <= w_wdata;
    else                              r_rd_entry <= r_table[w_lk_idx];
    r_rd_tag <= w_lk_tag;
  end

  // Init sweep sequencer. Any reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= '0;
    end else if (r_state == ST_INIT) begin
      r_sweep_idx <= r_sweep_idx + 1'b1;
      if (r_sweep_idx == INDEX_BITS'(DEPTH - 1)) r_state <= ST_RUN;
    end
  end

  // Outputs are forced quiet until the sweep has finished.
  always_comb begin
    o_ready      = (r_state == ST_RUN);
    o_valid      = o_ready && r_rd_entry.valid && (r_rd_entry.tag == r_rd_tag);
    o_prediction = o_valid && r_rd_entry.ctr[1];
    o_target     = o_valid ? r_rd_entry.tgt : '0;
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed testbench for branch_target_predictor. Inputs change on the falling
// edge and outputs are sampled on the next falling edge, so each step covers
// exactly one rising edge.
module tb_branch_target_predictor;

  localparam int AW = 26;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_pc_next;
  logic          i_update_valid;
  logic [AW-1:0] i_update_pc;
  logic          i_update_taken;
  logic [AW-1:0] i_update_target;
  logic          o_ready;
  logic          o_valid;
  logic          o_prediction;
  logic [AW-1:0] o_target;

  int nChecks = 0;
  int nErrors = 0;

  branch_target_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .i_pc_next      (i_pc_next),
    .i_update_valid (i_update_valid),
    .i_update_pc    (i_update_pc),
    .i_update_taken (i_update_taken),
    .i_update_target(i_update_target),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .o_prediction   (o_prediction),
    .o_target       (o_target)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then drop the update strobe.
  task automatic applyStimulus(input logic [AW-1:0] pcNext, input logic uv,
                               input logic [AW-1:0] upc, input logic ut,
                               input logic [AW-1:0] utgt);
    i_pc_next       = pcNext;
    i_update_valid  = uv;
    i_update_pc     = upc;
    i_update_taken  = ut;
    i_update_target = utgt;
    @(negedge clk);
    i_update_valid  = 1'b0;
  endtask

  // Check the three lookup outputs together.
  task automatic checkLookup(input string tag, input logic v, input logic p,
                             input logic [AW-1:0] t);
    checkOutput({tag, ".valid"}, 32'(o_valid), 32'(v));
    checkOutput({tag, ".pred"}, 32'(o_prediction), 32'(p));
    checkOutput({tag, ".target"}, 32'(o_target), 32'(t));
  endtask

  // Follow a full sweep from reset release. Ready must rise after exactly 64 edges.
  // If injectAt > 0, a taken update to PC 0 is driven on that sweep cycle; it must be ignored.
  task automatic sweepCheck(input string tag, input int injectAt);
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k == injectAt) applyStimulus(i_pc_next, 1'b1, 26'h000, 1'b1, 26'h044);
      else               applyStimulus(i_pc_next, 1'b0, 26'h000, 1'b0, 26'h000);
      checkOutput($sformatf("%s.ready@%0d", tag, k), 32'(o_ready), 32'(k == 64 ? 1 : 0));
      if (k < 64)
        checkOutput($sformatf("%s.valid@%0d", tag, k), 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    i_pc_next       = '0;
    i_update_valid  = 1'b0;
    i_update_pc     = '0;
    i_update_taken  = 1'b0;
    i_update_target = '0;

    // Test 1: reset state, then the initial sweep.
    repeat (3) @(negedge clk);
    checkOutput("rst.ready", 32'(o_ready), 32'd0);
    checkLookup("rst", 1'b0, 1'b0, 26'h0);
    sweepCheck("sweep1", 0);

    // Test 2: allocate on a taken miss, then look it up on the following cycle.
    applyStimulus(26'h000, 1'b1, 26'h040, 1'b1, 26'h100);
    checkLookup("miss0", 1'b0, 1'b0, 26'h0);
    applyStimulus(26'h040, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("alloc", 1'b1, 1'b1, 26'h100);

    // Test 3: counter saturates at both ends. Lookup is held on 0x040, so each step shows the post-update entry.
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b0, 26'h3F0);
    checkLookup("nt1", 1'b1, 1'b0, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b0, 26'h3F0);
    checkLookup("nt2", 1'b1, 1'b0, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b0, 26'h3F0);
    checkLookup("nt3sat", 1'b1, 1'b0, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b1, 26'h100);
    checkLookup("tk1", 1'b1, 1'b0, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b1, 26'h100);
    checkLookup("tk2", 1'b1, 1'b1, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b1, 26'h100);
    checkLookup("tk3", 1'b1, 1'b1, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b1, 26'h100);
    checkLookup("tk4", 1'b1, 1'b1, 26'h100);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b1, 26'h180);
    checkLookup("tk5sat", 1'b1, 1'b1, 26'h180);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b0, 26'h3F0);
    checkLookup("ntFrom11", 1'b1, 1'b1, 26'h180);
    applyStimulus(26'h040, 1'b1, 26'h040, 1'b0, 26'h3F0);
    checkLookup("ntTo01", 1'b1, 1'b0, 26'h180);

    // Test 4: 0x140 aliases index 16 and evicts 0x040. A not-taken miss from 0x240 must not write.
    applyStimulus(26'h000, 1'b1, 26'h140, 1'b1, 26'h300);
    applyStimulus(26'h040, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("alias040", 1'b0, 1'b0, 26'h0);
    applyStimulus(26'h140, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("alias140", 1'b1, 1'b1, 26'h300);
    applyStimulus(26'h140, 1'b1, 26'h240, 1'b0, 26'h3F0);
    checkLookup("ntMiss240", 1'b1, 1'b1, 26'h300);
    applyStimulus(26'h240, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("look240", 1'b0, 1'b0, 26'h0);

    // Test 5: same-cycle update and lookup of 0x080 (write-first bypass).
    applyStimulus(26'h080, 1'b1, 26'h080, 1'b1, 26'h200);
    checkLookup("bypass", 1'b1, 1'b1, 26'h200);

    // Test 6a: reset while in RUN with trained entries. Lookup stays on 0x080 (index 32) during the sweep.
    rst = 1'b1;
    applyStimulus(26'h080, 1'b0, 26'h000, 1'b0, 26'h000);
    checkOutput("rstRun.ready", 32'(o_ready), 32'd0);
    checkLookup("rstRun", 1'b0, 1'b0, 26'h0);

    // Test 6b: reset again at sweep index 30, before index 32 has been cleared.
    rst = 1'b0;
    repeat (30) applyStimulus(26'h080, 1'b0, 26'h000, 1'b0, 26'h000);
    checkOutput("mid30.ready", 32'(o_ready), 32'd0);
    checkOutput("mid30.valid", 32'(o_valid), 32'd0);
    rst = 1'b1;
    applyStimulus(26'h080, 1'b0, 26'h000, 1'b0, 26'h000);
    sweepCheck("sweep2", 40);

    // After the second sweep, every trained entry and the update ignored during INIT must miss.
    applyStimulus(26'h080, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("post080", 1'b0, 1'b0, 26'h0);
    applyStimulus(26'h140, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("post140", 1'b0, 1'b0, 26'h0);
    applyStimulus(26'h000, 1'b0, 26'h000, 1'b0, 26'h000);
    checkLookup("post000", 1'b0, 1'b0, 26'h0);
    checkOutput("post.ready", 32'(o_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
